path_metric_unit: RTL and testbench

- Add-compare-select (ACS) stage of the 8-state (K=4) Viterbi decoder.
- Sits directly downstream of the eight branch-metric cells (bmc000…bmc111) and consumes their path_0/path_1 metrics.
- Holds the eight registered path metrics, selects the survivor into each state, and emits one decision bit per state per symbol to the traceback memory.
- Also reports the best (minimum-metric) state, with normalization to keep metrics bounded.

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/acs_cell.sv | 36 +++
 rtl/path_metric_unit.sv | 141 ++++++++++++++
 tb/tb_path_metric_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, trellis helper and FSM encoding for the K=4, 8-state Viterbi decoder.
package viterbi_pkg;

  localparam int N_STATES = 8;
  localparam int BM_W     = 2;
  localparam int S_W      = 3;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } pmu_state_e;

  // Predecessor of state s on branch j: the oldest register bit is shifted out as j.
  function automatic logic [S_W-1:0] pred(input logic [S_W-1:0] s, input logic j);
    return {s[1:0], j};
  endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select slice: two candidate sums, survivor pick, and the reduction
// to PM_W bits (saturating unless PMU_NORM_EN is defined, where overflow cannot occur).
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [BM_W-1:0] i_bm0,
  input  logic [BM_W-1:0] i_bm1,
  output logic            o_dec,
  output logic [PM_W-1:0] o_pm
);

  localparam int CW = PM_W + 1;

  logic [CW-1:0] w_c0;
  logic [CW-1:0] w_c1;
  logic [CW-1:0] w_sel;

  assign w_c0  = {1'b0, i_pm0} + CW'(i_bm0);
  assign w_c1  = {1'b0, i_pm1} + CW'(i_bm1);
  // Strict compare: a tie keeps branch 0.
  assign o_dec = (w_c1 < w_c0);
  assign w_sel = o_dec ? w_c1 : w_c0;

`ifdef PMU_NORM_EN
  logic w_unused_carry;
  assign w_unused_carry = w_sel[PM_W];
  assign o_pm           = w_sel[PM_W-1:0];
`else
  assign o_pm = w_sel[PM_W] ? {PM_W{1'b1}} : w_sel[PM_W-1:0];
`endif

endmodule

// File: rtl/path_metric_unit.sv
// ACS stage of the 8-state Viterbi decoder: path-metric registers, decisions, run FSM and a
// two-stage best-state search. Define PMU_NORM_EN for MSB normalization instead of saturation.
module path_metric_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W    = 8,
  parameter int PM_INIT = 2**(PM_W-2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [4*N_STATES-1:0] bm,
  output logic                  valid_out,
  output logic [N_STATES-1:0]   dec,
  output logic                  best_valid,
  output logic [S_W-1:0]        best_state,
  output logic [PM_W-1:0]       best_pm
);

  typedef logic [PM_W-1:0] pm_t;
  typedef struct packed {
    logic [S_W-1:0] idx;
    pm_t            pm;
  } cand_t;

  pmu_state_e          r_state;
  pmu_state_e          w_state_next;
  pm_t                 r_pm      [N_STATES];
  pm_t                 w_acs_pm  [N_STATES];
  pm_t                 w_pm_next [N_STATES];
  logic [N_STATES-1:0] w_dec;
  logic [N_STATES-1:0] r_dec;
  logic                r_valid_out;
  logic                w_accept;
  cand_t               w_s1 [N_STATES/2];
  cand_t               r_s1 [N_STATES/2];
  logic                r_s1_valid;
  cand_t               w_m01;
  cand_t               w_m23;
  cand_t               w_best;
  cand_t               r_best;
  logic                r_best_valid;

  for (genvar s = 0; s < N_STATES; s++) begin : g_acs
    acs_cell #(.PM_W(PM_W)) u_acs (
      .i_pm0 (r_pm[pred(S_W'(s), 1'b0)]),
      .i_pm1 (r_pm[pred(S_W'(s), 1'b1)]),
      .i_bm0 (bm[4*s +: BM_W]),
      .i_bm1 (bm[4*s+2 +: BM_W]),
      .o_dec (w_dec[s]),
      .o_pm  (w_acs_pm[s])
    );
  end

`ifdef PMU_NORM_EN
  logic w_all_msb;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_all_msb = 1'b1;
    for (int s = 0; s < N_STATES; s++) w_all_msb &= w_acs_pm[s][PM_W-1];
    for (int s = 0; s < N_STATES; s++) begin
      w_pm_next[s] = w_acs_pm[s];
      if (w_all_msb) w_pm_next[s][PM_W-1] = 1'b0;
    end
  end
`else
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int s = 0; s < N_STATES; s++) w_pm_next[s] = w_acs_pm[s];
  end
`endif

  always_comb begin
    w_state_next = r_state;
    if (start) w_state_next = ST_RUN;
  end

  // start wins over a coincident symbol, which is then dropped.
  assign w_accept = (r_state == ST_RUN) && valid_in && !start;

  // NOTE: the eight metrics are ordinary flops, so they take the async reset like all other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_valid_out <= 1'b0;
      r_dec       <= '0;
      for (int s = 0; s < N_STATES; s++) r_pm[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_state     <= w_state_next;
      r_valid_out <= w_accept;
      if (start) begin
        r_pm[0] <= '0;
        for (int s = 1; s < N_STATES; s++) r_pm[s] <= pm_t'(PM_INIT);
      end else if (w_accept) begin
        r_pm  <= w_pm_next;
        r_dec <= w_dec;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < N_STATES/2; p++) begin
      if (w_pm_next[2*p+1] < w_pm_next[2*p]) begin
        w_s1[p].idx = S_W'(2*p + 1);
        w_s1[p].pm  = w_pm_next[2*p+1];
      end else begin
        w_s1[p].idx = S_W'(2*p);
        w_s1[p].pm  = w_pm_next[2*p];
      end
    end
  end

  // Lower-index operand sits on the right of each compare so ties keep the lower state.
  assign w_m01  = (r_s1[1].pm < r_s1[0].pm) ? r_s1[1] : r_s1[0];
  assign w_m23  = (r_s1[3].pm < r_s1[2].pm) ? r_s1[3] : r_s1[2];
  assign w_best = (w_m23.pm < w_m01.pm) ? w_m23 : w_m01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_best_valid <= 1'b0;
      r_best       <= '0;
      for (int p = 0; p < N_STATES/2; p++) r_s1[p] <= '0;
    end else begin
      r_s1_valid   <= w_accept;
      r_best_valid <= r_s1_valid;
      if (w_accept) r_s1 <= w_s1;
      if (r_s1_valid) r_best <= w_best;
    end
  end

  assign valid_out  = r_valid_out;
  assign dec        = r_dec;
  assign best_valid = r_best_valid;
  assign best_state = r_best.idx;
  assign best_pm    = r_best.pm;

endmodule

// File: tb/tb_path_metric_unit.sv
// Scoreboard bench for path_metric_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever valid_out / best_valid are high.
module tb_path_metric_unit;
  import viterbi_pkg::*;

  localparam int PM_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            valid_in = 1'b0;
  logic [31:0]     bm = '0;
  logic            valid_out;
  logic [7:0]      dec;
  logic            best_valid;
  logic [2:0]      best_state;
  logic [PM_W-1:0] best_pm;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  q_dec  [$];
  logic [10:0] q_best [$];

  path_metric_unit #(.PM_W(PM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .valid_in   (valid_in),
    .bm         (bm),
    .valid_out  (valid_out),
    .dec        (dec),
    .best_valid (best_valid),
    .best_state (best_state),
    .best_pm    (best_pm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        if (q_dec.size() == 0) check("unexpected valid_out", 32'd1, 32'd0);
        else check("dec", {24'd0, dec}, {24'd0, q_dec.pop_front()});
      end
      if (best_valid) begin
        if (q_best.size() == 0) check("unexpected best_valid", 32'd1, 32'd0);
        else begin
          logic [10:0] e;
          e = q_best.pop_front();
          check("best_state", {29'd0, best_state}, {29'd0, e[10:8]});
          check("best_pm", {24'd0, best_pm}, {24'd0, e[7:0]});
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic sym(input logic [31:0] b, input logic [7:0] edec,
                     input logic [2:0] es, input logic [7:0] epm);
    valid_in = 1'b1;
    bm       = b;
    q_dec.push_back(edec);
    q_best.push_back({es, epm});
    cycle();
    valid_in = 1'b0;
  endtask

  // All branches cost 2 except the one true transition (into state s on branch j).
  function automatic logic [31:0] one_zero(input int s, input int j);
    logic [31:0] b;
    b = 32'hAAAA_AAAA;
    b[4*s + 2*j +: 2] = 2'd0;
    return b;
  endfunction

  // All-2 stream: metrics become uniform 2k after symbol k.
  function automatic logic [7:0] stream_pm(input int k);
`ifdef PMU_NORM_EN
    return 8'((2*k) % 128);
`else
    return (2*k > 255) ? 8'd255 : 8'(2*k);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset valid_out", {31'd0, valid_out}, 32'd0);
    check("reset dec", {24'd0, dec}, 32'd0);
    check("reset best_valid", {31'd0, best_valid}, 32'd0);
    check("reset best_state", {29'd0, best_state}, 32'd0);
    check("reset best_pm", {24'd0, best_pm}, 32'd0);
    #12 rst_n = 1'b1;
    cycle();

    // IDLE ignores valid_in
    valid_in = 1'b1;
    bm = '0;
    cycle();
    cycle();
    valid_in = 1'b0;
    cycle();

    // all-zero branch metrics from a fresh start
    do_start();
    sym(32'h0, 8'h00, 3'd0, 8'd0);
    sym(32'h0, 8'h00, 3'd0, 8'd0);
    sym(32'h0, 8'h00, 3'd0, 8'd0);
    // equal metrics, branch 1 cheaper everywhere
    sym(32'h2222_2222, 8'hFF, 3'd0, 8'd0);
    sym(32'h2222_2222, 8'hFF, 3'd0, 8'd0);
    cycle();

    // error-free path for bits 1,0,1,1: states 4,2,5,6
    do_start();
    sym(one_zero(4, 0), 8'h00, 3'd4, 8'd0);
    sym(one_zero(2, 0), 8'h00, 3'd2, 8'd0);
    sym(one_zero(5, 0), 8'h00, 3'd5, 8'd0);
    sym(one_zero(6, 1), 8'hFF, 3'd6, 8'd0);
    cycle();
    cycle();

    // long all-2 stream: saturation or normalization
    do_start();
    for (int k = 1; k <= 135; k++) sym(32'hAAAA_AAAA, 8'h00, 3'd0, stream_pm(k));

    // start coincident with valid_in: that symbol is dropped, metrics reinit
    start    = 1'b1;
    valid_in = 1'b1;
    bm       = 32'h0;
    cycle();
    start    = 1'b0;
    sym(32'hAAAA_AAAA, 8'h00, 3'd0, 8'd2);
    sym(32'h2222_2222, 8'hAA, 3'd0, 8'd4);

    // reset mid-symbol while outputs are live
    valid_in = 1'b1;
    bm       = 32'h0;
    rst_n    = 1'b0;
    #1;
    check("async reset valid_out", {31'd0, valid_out}, 32'd0);
    check("async reset dec", {24'd0, dec}, 32'd0);
    check("async reset best_valid", {31'd0, best_valid}, 32'd0);
    check("async reset best_state", {29'd0, best_state}, 32'd0);
    check("async reset best_pm", {24'd0, best_pm}, 32'd0);
    q_dec.delete();
    q_best.delete();
    cycle();
    #4 rst_n = 1'b1;
    cycle();
    cycle();
    cycle();
    valid_in = 1'b0;
    cycle();

    do_start();
    sym(32'h0, 8'h00, 3'd0, 8'd0);

    for (int i = 0; i < 20 && (q_dec.size() + q_best.size()) != 0; i++) cycle();
    check("queues drained", q_dec.size() + q_best.size(), 32'd0);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
